// File: rtl/div_unit.sv
// Iterative signed divider: one restoring step per clock on a remainder/quotient
// shift register, with sign fix-up, divide-by-zero flag and a one-cycle ready pulse.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_mag;
    logic [5:0]       count;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   trial;

    always_comb begin
        mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_mag};
    end

    // The remainder is kept at WIDTH bits: a non-negative trial is always below
    // the shifted value, so the top bit of the 33-bit remainder is never set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            rem_q          <= '0;
            quo_q          <= '0;
            div_mag        <= '0;
            count          <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= (state == DONE);
            if (ctrl_DIV) begin
                rem_q   <= '0;
                quo_q   <= mag_a;
                div_mag <= mag_b;
                count   <= '0;
                sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                sign_r  <= data_operandA[WIDTH-1];
                if (data_operandB == '0) begin
                    data_result    <= '0;
                    data_remainder <= '0;
                    data_exception <= 1'b1;
                    state          <= DONE;
                end else begin
                    state <= RUN;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (!trial[WIDTH]) begin
                            rem_q <= trial[WIDTH-1:0];
                            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                        end
                        count <= count + 6'd1;
                        if (count == LAST_STEP) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        data_result    <= sign_q ? -quo_q : quo_q;
                        data_remainder <= sign_r ? -rem_q : rem_q;
                        data_exception <= 1'b0;
                        state          <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit plus hand-written abort, reset and
// back-to-back sequences.
module tb_div_unit;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_remainder(data_remainder),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Load edge happens inside; operands are scrambled afterwards.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int n);
        n = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY && n == 99) n = i;
            if (n != 99) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic seen;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
        vecs[2]  = '{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};
        vecs[3]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
        vecs[4]  = '{32'd5,          32'd0,          32'd0,          32'd0,          1'b1};
        vecs[5]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
        vecs[6]  = '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   32'd0,          1'b0};
        vecs[7]  = '{32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF,   1'b0};
        vecs[8]  = '{32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0};
        vecs[9]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[10] = '{32'd7,          32'd100,        32'd0,          32'd7,          1'b0};
        vecs[11] = '{32'hFFFFFFFF,   32'd2,          32'd0,          32'hFFFFFFFF,   1'b0};
        vecs[12] = '{32'hDEADBEEF,   32'd0,          32'd0,          32'd0,          1'b1};

        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        check("reset_result", data_result, 32'd0);
        check("reset_remainder", data_remainder, 32'd0);
        check("reset_exception", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 13; i++) begin
            start(vecs[i].a, vecs[i].b);
            wait_rdy(n);
            check($sformatf("v%0d_latency", i), n, (vecs[i].b == 32'd0) ? 32'd1 : 32'd34);
            check($sformatf("v%0d_result", i), data_result, vecs[i].q);
            check($sformatf("v%0d_remainder", i), data_remainder, vecs[i].r);
            check($sformatf("v%0d_exception", i), {31'd0, data_exception}, {31'd0, vecs[i].exc});
            @(posedge clock);
            #1;
            check($sformatf("v%0d_rdy_one_cycle", i), {31'd0, data_resultRDY}, 32'd0);
            check($sformatf("v%0d_exc_held", i), {31'd0, data_exception}, {31'd0, vecs[i].exc});
        end

        // Abort: reissue at edge 10 with new operands.
        start(32'd1000, 32'd3);
        seen = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen = 1'b1;
        end
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        check("abort_no_early_rdy", {31'd0, seen}, 32'd0);
        wait_rdy(n);
        check("abort_latency", n, 32'd34);
        check("abort_result", data_result, 32'd10);
        check("abort_remainder", data_remainder, 32'd0);
        @(posedge clock);
        #1;

        // Asynchronous reset in the middle of a run.
        start(32'd1000, 32'd3);
        repeat (14) @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_result", data_result, 32'd0);
        check("async_rst_remainder", data_remainder, 32'd0);
        check("async_rst_exception", {31'd0, data_exception}, 32'd0);
        check("async_rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        #2;
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen = 1'b1;
        end
        check("async_rst_no_rdy", {31'd0, seen}, 32'd0);
        start(32'd9, 32'd2);
        wait_rdy(n);
        check("post_rst_latency", n, 32'd34);
        check("post_rst_result", data_result, 32'd4);
        check("post_rst_remainder", data_remainder, 32'd1);
        @(posedge clock);
        #1;

        // Back-to-back: new start sampled on the ready edge.
        start(32'd100, 32'd7);
        seen = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen = 1'b1;
        end
        check("b2b_no_early_rdy", {31'd0, seen}, 32'd0);
        check("b2b_valid_at_fix", data_result, 32'd14);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'hFFFFFF9C;
        data_operandB = 32'd7;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        check("b2b_rdy_completes", {31'd0, data_resultRDY}, 32'd1);
        check("b2b_first_result", data_result, 32'd14);
        check("b2b_first_remainder", data_remainder, 32'd2);
        wait_rdy(n);
        check("b2b_second_latency", n, 32'd34);
        check("b2b_second_result", data_result, 32'hFFFFFFF2);
        check("b2b_second_remainder", data_remainder, 32'hFFFFFFFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
